// File: rtl/backprop_layer_sequencer_pkg.sv
// Shared types and constants for the backprop layer sequencer.
// Optional feature macro: BACKPROP_SEQ_PERF_EN (stall cycle counter).
package backprop_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    // Take-to-output latency: prep skew (size-1) plus systolic delay (size).
    function automatic int lat(input int size);
        return 2 * size - 1;
    endfunction

endpackage

// File: rtl/backprop_layer_sequencer_if.sv
// Control/status bundle between the host side and the layer sequencer.
// Optional feature macro: BACKPROP_SEQ_PERF_EN adds stall_cycles.
interface backprop_layer_sequencer_if #(
    parameter int size       = 3,
    parameter int layers_max = 8
);
    localparam int num_w   = $clog2(layers_max + 1);
    localparam int layer_w = $clog2(layers_max);
    localparam int row_w   = $clog2(size);

    logic               start;
    logic [num_w-1:0]   num_layers;
    logic               abort;
    logic               row_ready;
    logic               row_take;
    logic               set_diff_act;
    logic               start_new_layer;
    logic [layer_w-1:0] layer_idx;
    logic               z_valid;
    logic [row_w-1:0]   z_row_idx;
    logic               busy;
    logic               done;
`ifdef BACKPROP_SEQ_PERF_EN
    logic [15:0]        stall_cycles;

    modport master (
        output start, num_layers, abort, row_ready,
        input  row_take, set_diff_act, start_new_layer, layer_idx,
               z_valid, z_row_idx, busy, done, stall_cycles
    );
    modport slave (
        input  start, num_layers, abort, row_ready,
        output row_take, set_diff_act, start_new_layer, layer_idx,
               z_valid, z_row_idx, busy, done, stall_cycles
    );
`else
    modport master (
        output start, num_layers, abort, row_ready,
        input  row_take, set_diff_act, start_new_layer, layer_idx,
               z_valid, z_row_idx, busy, done
    );
    modport slave (
        input  start, num_layers, abort, row_ready,
        output row_take, set_diff_act, start_new_layer, layer_idx,
               z_valid, z_row_idx, busy, done
    );
`endif
endinterface

// File: rtl/backprop_layer_sequencer_valid_tracker.sv
// Tracks which datapath beats are real rows as they travel through the
// fixed-latency pipeline. A take enters stage 0 and emerges as z_valid
// exactly depth cycles later; bubbles travel as invalid entries.
module valid_tracker #(
    parameter int depth = 5,
    parameter int idx_w = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [idx_w-1:0] in_idx,
    output logic             z_valid,
    output logic [idx_w-1:0] z_row_idx,
    output logic             empty
);

    logic [depth-1:0] vld;
    logic [idx_w-1:0] idx [depth];

    // Shift the {valid, row} pairs one stage per cycle; flush drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld <= '0;
            for (int i = 0; i < depth; i++) idx[i] <= '0;
        end else begin
            vld    <= {vld[depth-2:0], in_valid};
            idx[0] <= in_valid ? in_idx : '0;
            for (int i = 1; i < depth; i++) idx[i] <= idx[i-1];
        end
    end

    assign z_valid   = vld[depth-1];
    assign z_row_idx = idx[depth-1];
    // Nothing in flight behind the output stage: the beat now at the output
    // (if any) is the last one.
    assign empty     = ~|vld[depth-2:0];

endmodule

// File: rtl/backprop_layer_sequencer.sv
// Backprop layer sequencer: streams size rows per layer into the
// diff_z_to_z datapath, waits for the pipeline to drain, repeats for
// num_layers layers, then pulses done.
// Optional feature macro: BACKPROP_SEQ_PERF_EN adds the stall_cycles counter.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | taking rows of the current layer as row_ready allows
// DRAIN  | all rows taken, waiting for the last beat to leave the pipeline
// DONE   | one-cycle completion pulse
module backprop_layer_sequencer
    import backprop_pkg::*;
#(
    parameter int data_size  = 16,
    parameter int size       = 3,
    parameter int layers_max = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    backprop_layer_sequencer_if.slave     bus
);

    localparam int num_w     = $clog2(layers_max + 1);
    localparam int layer_w   = $clog2(layers_max);
    localparam int row_w     = $clog2(size);
    localparam int lat_depth = lat(size);

    if (size < 2 || data_size < 1) begin : g_param_check
        $error("backprop_layer_sequencer: size must be >= 2 and data_size >= 1");
    end

    seq_state_t         state;
    logic [row_w-1:0]   row_cnt;
    logic [layer_w-1:0] layer_idx;
    logic [num_w-1:0]   num_q;
    logic               busy_q;
    logic               done_q;
    logic               take;
    logic               first_row;
    logic               last_layer;
    logic               trk_empty;

    assign take       = (state == STREAM) && bus.row_ready;
    assign first_row  = take && (row_cnt == '0);
    assign last_layer = (num_w'(layer_idx) + num_w'(1)) == num_q;

    // Sequencing FSM with registered layer index, busy and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row_cnt   <= '0;
            layer_idx <= '0;
            num_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.abort) begin
            state     <= IDLE;
            row_cnt   <= '0;
            layer_idx <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        num_q     <= bus.num_layers;
                        layer_idx <= '0;
                        row_cnt   <= '0;
                        busy_q    <= 1'b1;
                        if (bus.num_layers == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (take) begin
                        if (row_cnt == row_w'(size - 1)) begin
                            row_cnt <= '0;
                            state   <= DRAIN;
                        end else begin
                            row_cnt <= row_cnt + row_w'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (trk_empty) begin
                        if (last_layer) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            layer_idx <= layer_idx + layer_w'(1);
                            row_cnt   <= '0;
                            state     <= STREAM;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    layer_idx <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    valid_tracker #(
        .depth (lat_depth),
        .idx_w (row_w)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.abort),
        .in_valid  (take),
        .in_idx    (row_cnt),
        .z_valid   (bus.z_valid),
        .z_row_idx (bus.z_row_idx),
        .empty     (trk_empty)
    );

    assign bus.row_take        = take;
    assign bus.set_diff_act    = first_row;
    assign bus.start_new_layer = first_row;
    assign bus.layer_idx       = layer_idx;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

`ifdef BACKPROP_SEQ_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of STREAM cycles with no row available; restarts per pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state == IDLE && bus.start && !bus.abort) begin
            stall_q <= '0;
        end else if (state == STREAM && !bus.row_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_backprop_layer_sequencer.sv
// Self-checking bench for backprop_layer_sequencer (size=3, LAT=5).
// Expected waveforms come from an event-timeline model: each layer's takes
// are placed on the next ready cycles, outputs appear LAT later, the next
// layer begins the cycle after the last output, abort truncates the timeline.
module tb_backprop_layer_sequencer;

    localparam int size       = 3;
    localparam int layers_max = 8;
    localparam int lat_c      = 2 * size - 1;
    localparam int ncyc       = 100;
    localparam int num_w      = $clog2(layers_max + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    backprop_layer_sequencer_if #(.size(size), .layers_max(layers_max)) bus ();

    backprop_layer_sequencer #(
        .data_size  (16),
        .size       (size),
        .layers_max (layers_max)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    bit rdy_pat [ncyc];
    bit e_take  [ncyc];
    bit e_first [ncyc];
    bit e_zv    [ncyc];
    bit e_done  [ncyc];
    bit e_busy  [ncyc];
    int e_zi    [ncyc];
    int e_layer [ncyc];
    int e_stall;
    int m_end;

    typedef struct {
        int      nl;
        bit [31:0] mask;
        int      ab;
        int      xs;
        bit      rst;
        int      exp_done;
        int      exp_takes;
        int      exp_zv;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int c, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    function automatic bit ready_at(input int c);
        return (c >= ncyc) ? 1'b1 : rdy_pat[c];
    endfunction

    task automatic build_model(input int nl, input int ab);
        int c;
        int done_c;
        for (int i = 0; i < ncyc; i++) begin
            e_take[i] = 0; e_first[i] = 0; e_zv[i] = 0; e_done[i] = 0;
            e_busy[i] = 0; e_zi[i] = 0; e_layer[i] = 0;
        end
        e_stall = 0;
        c = 1;
        if (nl == 0) begin
            done_c = 1;
        end else begin
            for (int k = 0; k < nl; k++) begin
                int lstart;
                int last;
                lstart = c;
                last = c;
                for (int r = 0; r < size; r++) begin
                    while (!ready_at(c)) begin
                        if (ab < 0 || c <= ab) e_stall++;
                        c++;
                    end
                    if (c < ncyc) begin
                        e_take[c]  = 1;
                        e_first[c] = (r == 0);
                    end
                    if (c + lat_c < ncyc) begin
                        e_zv[c + lat_c] = 1;
                        e_zi[c + lat_c] = r;
                    end
                    last = c;
                    c++;
                end
                for (int t = lstart; t <= last + lat_c && t < ncyc; t++) e_layer[t] = k;
                c = last + lat_c + 1;
            end
            done_c = c;
        end
        m_end = done_c;
        if (done_c < ncyc) begin
            e_done[done_c]  = 1;
            e_layer[done_c] = (nl == 0) ? 0 : nl - 1;
        end
        for (int t = 1; t <= done_c && t < ncyc; t++) e_busy[t] = 1;
        if (ab >= 0) begin
            for (int t = ab + 1; t < ncyc; t++) begin
                e_take[t] = 0; e_first[t] = 0; e_zv[t] = 0; e_done[t] = 0;
                e_busy[t] = 0; e_zi[t] = 0; e_layer[t] = 0;
            end
        end
    endtask

    task automatic run_scenario(input int nl, input int ab, input int xs, input bit do_reset,
                                output int obs_done, output int obs_takes, output int obs_zv);
        build_model(nl, ab);
        obs_done = -1; obs_takes = 0; obs_zv = 0;
        if (do_reset) begin
            reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.row_ready = 1'b0;
            bus.num_layers = '0;
            @(posedge clk); #1;
            reset = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            bus.start      = (c == 0) || (c == xs);
            bus.num_layers = num_w'(nl);
            bus.abort      = (c == ab);
            bus.row_ready  = rdy_pat[c];
            @(negedge clk);
            chk("row_take",        c, int'(bus.row_take),        int'(e_take[c]));
            chk("set_diff_act",    c, int'(bus.set_diff_act),    int'(e_first[c]));
            chk("start_new_layer", c, int'(bus.start_new_layer), int'(e_first[c]));
            chk("z_valid",         c, int'(bus.z_valid),         int'(e_zv[c]));
            chk("busy",            c, int'(bus.busy),            int'(e_busy[c]));
            chk("done",            c, int'(bus.done),            int'(e_done[c]));
            chk("layer_idx",       c, int'(bus.layer_idx),       e_layer[c]);
            if (e_zv[c]) chk("z_row_idx", c, int'(bus.z_row_idx), e_zi[c]);
            if (bus.row_take) obs_takes++;
            if (bus.z_valid) obs_zv++;
            if (bus.done && obs_done < 0) obs_done = c;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
`ifdef BACKPROP_SEQ_PERF_EN
        chk("stall_cycles", ncyc, int'(bus.stall_cycles), e_stall);
`endif
    endtask

    task automatic reset_mid(input int nl, input int rc);
        reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.row_ready = 1'b1;
        bus.num_layers = num_w'(nl);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c <= rc + 1; c++) begin
            bus.start = (c == 0);
            reset     = (c == rc);
            @(negedge clk);
            if (c == rc) chk("busy_before_reset", c, int'(bus.busy), 1);
            if (c == rc + 1) begin
                chk("rst_row_take",     c, int'(bus.row_take),        0);
                chk("rst_set_diff_act", c, int'(bus.set_diff_act),    0);
                chk("rst_start_new",    c, int'(bus.start_new_layer), 0);
                chk("rst_layer_idx",    c, int'(bus.layer_idx),       0);
                chk("rst_z_valid",      c, int'(bus.z_valid),         0);
                chk("rst_z_row_idx",    c, int'(bus.z_row_idx),       0);
                chk("rst_busy",         c, int'(bus.busy),            0);
                chk("rst_done",         c, int'(bus.done),            0);
`ifdef BACKPROP_SEQ_PERF_EN
                chk("rst_stall_cycles", c, int'(bus.stall_cycles),    0);
`endif
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int od, ot, oz;
        int nl, ab, xs, lim;

        vecs[0] = '{2, 32'hFFFF_FFFF, -1, -1, 1'b1, 17, 6, 6};
        vecs[1] = '{1, 32'hFFFF_FFFB, -1, -1, 1'b1, 10, 3, 3};
        vecs[2] = '{0, 32'hFFFF_FFFF, -1, -1, 1'b1,  1, 0, 0};
        vecs[3] = '{2, 32'hFFFF_FFFF,  3, -1, 1'b1, -1, 3, 0};
        vecs[4] = '{1, 32'hFFFF_FFFF, -1, -1, 1'b0,  9, 3, 3};
        vecs[5] = '{1, 32'hFFFF_FFFF, -1,  5, 1'b1,  9, 3, 3};
        vecs[6] = '{3, 32'hFFFF_FFFF, -1, -1, 1'b1, 25, 9, 9};

        for (int i = 0; i < 7; i++) begin
            for (int c = 0; c < ncyc; c++) rdy_pat[c] = (c < 32) ? vecs[i].mask[c] : 1'b1;
            run_scenario(vecs[i].nl, vecs[i].ab, vecs[i].xs, vecs[i].rst, od, ot, oz);
            chk("vec_done_cycle", i, od, vecs[i].exp_done);
            chk("vec_takes",      i, ot, vecs[i].exp_takes);
            chk("vec_z_valids",   i, oz, vecs[i].exp_zv);
`ifdef BACKPROP_SEQ_PERF_EN
            if (i == 1) chk("vec_stall_cycles", i, int'(bus.stall_cycles), 1);
`endif
        end

        reset_mid(2, 7);
        reset_mid(1, 2);
        reset_mid(2, 12);

        for (int s = 0; s < 40; s++) begin
            nl = $urandom_range(0, 4);
            for (int c = 0; c < ncyc; c++) rdy_pat[c] = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1;
            build_model(nl, -1);
            lim = (ab >= 0 && ab < m_end) ? ab : m_end;
            xs = (lim >= 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, lim)) : -1;
            run_scenario(nl, ab, xs, 1'b1, od, ot, oz);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/backprop_layer_sequencer.md
BACKPROP_LAYER_SEQUENCER -- requirements
Module: backprop_layer_sequencer

Interface
REQ-001 Parameter data_size, default 16, element width of the z-to-z datapath (no port depends on it; carried for instantiation symmetry).
REQ-002 Parameter size, default 3, rows per layer (systolic dimension).
REQ-003 Parameter layers_max, default 8, maximum layers per backprop pass.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all state updates on posedge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  request a backprop pass; sampled only in IDLE.
REQ-008 num_layers  in  $clog2(layers_max+1)  layer count, latched on accepted start.
REQ-009 abort  in  1  cancel the pass in progress.
REQ-010 row_ready  in  1  upstream diff_dense/diff_act row available this cycle.
REQ-011 row_take  out  1  row consumed this cycle.
REQ-012 set_diff_act  out  1  load diff_act into the datapath activation register.
REQ-013 start_new_layer  out  1  first-row marker for the datapath.
REQ-014 layer_idx  out  $clog2(layers_max)  current layer.
REQ-015 z_valid  out  1  diff_z_to_z output row valid.
REQ-016 z_row_idx  out  $clog2(size)  row index of the valid output.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at pass completion.

Function
REQ-019 FSM states IDLE, STREAM, DRAIN, DONE.
REQ-020 IDLE: start=1 and abort=0 latches num_layers; num_layers=0 -> DONE, otherwise -> STREAM with layer_idx=0 and row counter=0.
REQ-021 STREAM: row_take=row_ready combinationally; each take increments the row counter; the take with counter=size-1 -> DRAIN.
REQ-022 set_diff_act=start_new_layer=1 only on the take with row counter=0.
REQ-023 Pipeline latency LAT=2*size-1 cycles (prep skew size-1 plus delay size); z_valid=1 exactly LAT cycles after each take, with z_row_idx equal to that take's row counter.
REQ-024 row_ready=0 in STREAM is a stall: no take and counter held; bubbles propagate through the tracker and produce no z_valid.
REQ-025 DRAIN: exit on the cycle the last in-flight beat asserts z_valid; layer_idx=num_layers-1 -> DONE, otherwise layer_idx+1 and row counter=0 -> STREAM.
REQ-026 DONE: done=1 and busy=1 for one cycle, then -> IDLE.
REQ-027 start outside IDLE is ignored.
REQ-028 abort=1 in any state -> IDLE next cycle, tracker flushed, no done, no further z_valid; abort together with start in IDLE -> stays IDLE.

Reset
REQ-029 Reset forces IDLE, clears counters and tracker, and drives every output to 0, including mid-STREAM and mid-DRAIN.

Configuration
REQ-030 Macro BACKPROP_SEQ_PERF_EN defined: output stall_cycles (16 bits) counts STREAM cycles with row_ready=0, clears on accepted start, saturates at 0xFFFF.
REQ-031 BACKPROP_SEQ_PERF_EN undefined: port and counter absent, all other behaviour identical.

Structure
REQ-032 Package backprop_pkg holds the FSM state enum and the LAT(size) constant function.
REQ-033 Sub-module valid_tracker: LAT-deep shift register of {valid, row_idx}, with flush, producing z_valid/z_row_idx and an empty flag.

Verification
Settings: size=3 (LAT=5); start is sampled at the edge ending cycle 0.
REQ-034 num_layers=2, row_ready=1: takes at 1-3 and 9-11; set_diff_act at 1 and 9; z_valid at 6-8 and 14-16 with z_row_idx 0,1,2; done at 17; busy during 1-17.
REQ-035 num_layers=1, row_ready=0 at cycle 2 only: takes at 1,3,4; z_valid at 6,8,9; stall_cycles=1 (PERF_EN defined).
REQ-036 num_layers=0: done at 1, no row_take, no z_valid.
REQ-037 abort at 3 during layer 0: IDLE at 4, busy=0, no z_valid, no done; a new start then completes normally.
REQ-038 start pulsed at 5 while busy: ignored, pass timing unchanged; reset at 7 clears every output at 8.
